// File: rtl/joystick_cursor_stepper.sv
// joystick_cursor_stepper
//   Turns per-axis joystick direction codes into a cursor position on a square
//   CANVAS_SIZE x CANVAS_SIZE canvas with typematic stepping: one step at once,
//   a first-repeat delay of REPEAT_DELAY cycles, then one step per STEP_CYCLES.
//   Direction codes: 0 none, 1 increment, 2 decrement, 3 treated as none.
//   Optional build macro JOYSTICK_CURSOR_WRAP_EN: edges wrap modulo CANVAS_SIZE
//   instead of clamping; o_blocked then never pulses and every step pulses o_moved.
module joystick_cursor_stepper #(
  parameter int  CANVAS_SIZE  = 32,
  parameter int  START_X      = 16,
  parameter int  START_Y      = 16,
  parameter int  REPEAT_DELAY = 50_000_000,
  parameter int  STEP_CYCLES  = 10_000_000,
  localparam int PW           = $clog2(CANVAS_SIZE)
) (
  input  logic            CLK100MHZ,
  input  logic            reset,
  input  logic            i_en,
  input  logic [1:0]      i_x_dir,
  input  logic [1:0]      i_y_dir,
  output logic [PW-1:0]   o_pos_x,
  output logic [PW-1:0]   o_pos_y,
  output logic [2*PW-1:0] o_index,
  output logic            o_moved,
  output logic            o_blocked
);

  // Counter is sized for the longer of the two intervals it has to time.
  localparam int CNT_MAX = (REPEAT_DELAY > STEP_CYCLES) ? REPEAT_DELAY : STEP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(STEP_CYCLES - 1);

  localparam logic [PW-1:0] POS_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] POS_ONE  = PW'(1);
  localparam logic [PW-1:0] POS_MAX  = PW'(CANVAS_SIZE - 1);
  localparam logic [PW-1:0] POS_X0   = PW'(START_X);
  localparam logic [PW-1:0] POS_Y0   = PW'(START_Y);

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_INC  = 2'd1;
  localparam logic [1:0] DIR_DEC  = 2'd2;
  localparam logic [1:0] DIR_BAD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // Code 3 is folded onto "none" at capture, so a 0<->3 flip is not a direction change.
  function automatic logic [1:0] norm_dir(input logic [1:0] d);
    logic [1:0] r;
    r = (d == DIR_BAD) ? DIR_NONE : d;
    return r;
  endfunction

  // One axis of a step. Result packs {moved, blocked, next_position}.
  function automatic logic [PW+1:0] step_axis(input logic [PW-1:0] pos,
                                              input logic [1:0]    dir);
    logic [PW-1:0] nxt;
    logic          mov;
    logic          blk;
    nxt = pos;
    mov = 1'b0;
    blk = 1'b0;
    case (dir)
`ifdef JOYSTICK_CURSOR_WRAP_EN
      // Power-of-two canvas: natural PW-bit overflow is the modulo wrap.
      DIR_INC: begin
        nxt = pos + POS_ONE;
        mov = 1'b1;
      end
      DIR_DEC: begin
        nxt = pos - POS_ONE;
        mov = 1'b1;
      end
`else
      DIR_INC: begin
        if (pos == POS_MAX) begin
          blk = 1'b1;
        end else begin
          nxt = pos + POS_ONE;
          mov = 1'b1;
        end
      end
      DIR_DEC: begin
        if (pos == POS_ZERO) begin
          blk = 1'b1;
        end else begin
          nxt = pos - POS_ONE;
          mov = 1'b1;
        end
      end
`endif
      default: begin
        nxt = pos;
      end
    endcase
    return {mov, blk, nxt};
  endfunction

  logic [1:0]    dir_x_q, dir_y_q;
  logic [1:0]    prev_x_q, prev_y_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_s;
  logic          active_s;
  logic          changed_s;
  logic [PW+1:0] ax_x_s, ax_y_s;
  logic [PW-1:0] pos_x_q, pos_x_d;
  logic [PW-1:0] pos_y_q, pos_y_d;
  logic          moved_q, moved_d;
  logic          blocked_q, blocked_d;

  // Input capture stage plus a one-cycle-old copy used to spot direction changes.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      dir_x_q  <= DIR_NONE;
      dir_y_q  <= DIR_NONE;
      prev_x_q <= DIR_NONE;
      prev_y_q <= DIR_NONE;
    end else begin
      dir_x_q  <= norm_dir(i_x_dir);
      dir_y_q  <= norm_dir(i_y_dir);
      prev_x_q <= dir_x_q;
      prev_y_q <= dir_y_q;
    end
  end

  assign active_s  = i_en && ((dir_x_q != DIR_NONE) || (dir_y_q != DIR_NONE));
  assign changed_s = (dir_x_q != prev_x_q) || (dir_y_q != prev_y_q);

  // Typematic sequencing: decide when a step fires and where the timer goes next.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        if (active_s) begin
          step_s  = 1'b1;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!active_s) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (changed_s) begin
          // New direction restarts the initial delay with an immediate step.
          step_s  = 1'b1;
          cnt_d   = CNT_ZERO;
          state_d = ST_HOLD;
        end else if (cnt_q == DELAY_LAST) begin
          step_s  = 1'b1;
          cnt_d   = CNT_ZERO;
          state_d = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_REPEAT: begin
        if (!active_s) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (changed_s) begin
          step_s  = 1'b1;
          cnt_d   = CNT_ZERO;
          state_d = ST_HOLD;
        end else if (cnt_q == RATE_LAST) begin
          step_s  = 1'b1;
          cnt_d   = CNT_ZERO;
          state_d = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Per-axis step outcome, evaluated every cycle and only applied on a step.
  always_comb begin
    ax_x_s = step_axis(pos_x_q, dir_x_q);
    ax_y_s = step_axis(pos_y_q, dir_y_q);
  end

  // Next position and event pulses; pulses are zero on any non-step cycle.
  always_comb begin
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    moved_d   = 1'b0;
    blocked_d = 1'b0;
    if (step_s) begin
      pos_x_d   = ax_x_s[PW-1:0];
      pos_y_d   = ax_y_s[PW-1:0];
      moved_d   = ax_x_s[PW+1] | ax_y_s[PW+1];
      blocked_d = ax_x_s[PW]   | ax_y_s[PW];
    end else begin
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      moved_d   = 1'b0;
      blocked_d = 1'b0;
    end
  end

  // State, timer, position and pulse registers; reset wins over any pending step.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      pos_x_q   <= POS_X0;
      pos_y_q   <= POS_Y0;
      moved_q   <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      moved_q   <= moved_d;
      blocked_q <= blocked_d;
    end
  end

  assign o_pos_x   = pos_x_q;
  assign o_pos_y   = pos_y_q;
  assign o_index   = {pos_y_q, pos_x_q};
  assign o_moved   = moved_q;
  assign o_blocked = blocked_q;

endmodule
